// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RV32I decode-stage control unit with a registered D->E
// control bundle, valid/ready handshake, optional multi-cycle M-extension ops.
module decode_ctrl_pipe #(
    parameter bit          EN_M    = 1'b1,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrD,
    input  logic        validD,
    input  logic        flushE,
    output logic        readyD,
    output logic [2:0]  ImmSrcD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        JumpE,
    output logic        ALUSrcE,
    output logic        SrcAsrcE,
    output logic        jumpRegE,
    output logic [1:0]  ResultSrcE,
    output logic [1:0]  ALUOpE,
    output logic        MulDivE,
    output logic [2:0]  mdOpE,
    output logic        illegalE,
    output logic        validE
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic       src_a_src;
        logic       jump_reg;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       mul_div;
        logic [2:0] md_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused;

    ctrl_t      dec;
    ctrl_t      e_q;
    logic [2:0] imm_src;

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic       valid_q;
    logic       valid_n;
    logic       load;

    assign opcode = instrD[6:0];
    assign funct3 = instrD[14:12];
    assign funct7 = instrD[31:25];
    assign unused = ^{instrD[24:15], instrD[11:7]};

    // Opcode decode into the control bundle; unknown encodings flag illegal.
    always_comb begin
        dec     = '0;
        imm_src = 3'b000;
        unique case (opcode)
            7'b0000011: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                dec.jump_reg   = 1'b1;
            end
            7'b0100011: begin
                imm_src        = 3'b001;
                dec.alu_src    = 1'b1;
                dec.mem_write  = 1'b1;
                dec.jump_reg   = 1'b1;
            end
            7'b0110011: begin
                unique case (funct7)
                    7'b0000000, 7'b0100000: begin
                        dec.reg_write = 1'b1;
                        dec.alu_op    = 2'b10;
                        dec.jump_reg  = 1'b1;
                    end
                    7'b0000001: begin
                        if (EN_M) begin
                            dec.reg_write = 1'b1;
                            dec.alu_op    = 2'b10;
                            dec.jump_reg  = 1'b1;
                            dec.mul_div   = 1'b1;
                            dec.md_op     = funct3;
                        end else begin
                            dec.illegal   = 1'b1;
                        end
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = 2'b10;
                dec.jump_reg   = 1'b1;
            end
            7'b1100011: begin
                imm_src        = 3'b010;
                dec.branch     = 1'b1;
                dec.alu_op     = 2'b01;
                dec.jump_reg   = 1'b1;
            end
            7'b0110111: begin
                imm_src        = 3'b100;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b11;
                dec.jump_reg   = 1'b1;
            end
            7'b0010111: begin
                imm_src        = 3'b100;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.src_a_src  = 1'b1;
                dec.jump_reg   = 1'b1;
            end
            7'b1101111: begin
                imm_src        = 3'b011;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.src_a_src  = 1'b1;
                dec.jump_reg   = 1'b1;
            end
            7'b1100111: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign readyD  = (state == IDLE);
    assign ImmSrcD = imm_src;

    // Next-state: flush wins, then accept in IDLE, then busy countdown.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        valid_n = 1'b0;
        load    = 1'b0;
        if (flushE) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (validD) begin
                        load = 1'b1;
                        if (dec.mul_div) begin
                            cnt_n   = funct3[2] ? DIV_CNT : MUL_CNT;
                            state_n = BUSY;
                        end else begin
                            valid_n = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        valid_n = 1'b1;
                        cnt_n   = 4'd0;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = cnt - 4'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, busy counter and E-stage valid register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            valid_q <= valid_n;
        end
    end

    // E-stage control bundle: loads on accept, flush clears M/illegal tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
        end else if (flushE) begin
            e_q.mul_div <= 1'b0;
            e_q.illegal <= 1'b0;
        end else if (load) begin
            e_q <= dec;
        end
    end

    assign validE     = valid_q;
    assign RegWriteE  = e_q.reg_write & valid_q;
    assign MemWriteE  = e_q.mem_write & valid_q;
    assign BranchE    = e_q.branch & valid_q;
    assign JumpE      = e_q.jump & valid_q;
    assign ALUSrcE    = e_q.alu_src;
    assign SrcAsrcE   = e_q.src_a_src;
    assign jumpRegE   = e_q.jump_reg;
    assign ResultSrcE = e_q.result_src;
    assign ALUOpE     = e_q.alu_op;
    assign MulDivE    = e_q.mul_div;
    assign mdOpE      = e_q.md_op;
    assign illegalE   = e_q.illegal;

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered decode-stage control unit for the pipelined RV32I core. It decodes the opcode into the standard control bundle and captures it into the D→E pipeline register under a valid/ready handshake. It adds an optional M-extension path, where multiply and divide hold decode through a parametrised multi-cycle busy counter. It supports flush for branch/jump recovery and flags illegal encodings instead of silently emitting a NOP.

## Interface
- EN_M, 1: 1 = decode M-extension (OP opcode, funct7=0000001); 0 = such encodings are illegal
- MUL_LAT, 2: extra busy cycles for mul/mulh/mulhsu/mulhu (funct3[2]=0); range 1..15
- DIV_LAT, 8: extra busy cycles for div/divu/rem/remu (funct3[2]=1); range 1..15

- clk  in  1  clock; one clock domain, all state on rising edge
- reset  in  1  asynchronous, active-high
- instrD  in  32  instruction in decode
- validD  in  1  instrD is valid
- flushE  in  1  kill E register contents and abort any busy M op
- readyD  out  1  block can accept; combinational, = (state==IDLE)
- ImmSrcD  out  3  combinational immediate select for the D-stage extender
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, SrcAsrcE, jumpRegE  out  1 each  registered controls
- ResultSrcE, ALUOpE  out  2 each  registered controls
- MulDivE  out  1  E instruction is an M op
- mdOpE  out  3  funct3 of the M op; 0 otherwise
- illegalE  out  1  E instruction is an illegal encoding
- validE  out  1  E register holds an instruction to execute this cycle

## Operation
- Decoding uses opcode = instrD[6:0]. Fields are listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, SrcAsrc, jumpReg:
  - 0000011 load: 1,000,1,0,01,0,00,0,0,1
  - 0100011 store: 0,001,1,1,00,0,00,0,0,1
  - 0110011 R-type: 1,000,0,0,00,0,10,0,0,1
  - 0010011 I-ALU: 1,000,1,0,00,0,10,0,0,1
  - 1100011 branch: 0,010,0,0,00,1,01,0,0,1
  - 0110111 lui: 1,100,1,0,11,0,00,0,0,1
  - 0010111 auipc: 1,100,1,0,00,0,00,0,1,1
  - 1101111 jal: 1,011,0,0,10,0,00,1,1,1
  - 1100111 jalr: 1,000,0,0,10,0,00,1,0,0
- M op: opcode 0110011 with funct7=0000001 and EN_M=1. Its bundle is the R-type bundle plus MulDiv=1 and mdOp=funct3.
- Illegal encodings are:
  - any other opcode;
  - OP with funct7 not 0000000/0100000/(0000001 when EN_M=1).
  - For an illegal encoding, all fields are 0, illegal=1, and the instruction retires to E as a normal one-cycle instruction (validE=1).
- States are IDLE and BUSY. A counter cnt of width 4 resets to 0.
- Accept occurs at a rising edge when validD & readyD & !flushE. The E register then loads the bundle.
  - Non-M: validE←1, stay in IDLE.
  - M: validE←0, cnt←(funct3[2] ? DIV_LAT : MUL_LAT), go to BUSY.
- In BUSY, cnt decrements each edge. At the edge where cnt==1: validE←1, cnt←0, go to IDLE. Bundle fields hold throughout BUSY.
- In IDLE with no accept: validE←0 (bubble) and fields hold.
- Output gating: RegWriteE, MemWriteE, BranchE, JumpE = registered value & validE. Bubbles and busy cycles can never write or redirect.
- flushE has highest priority at any edge, in any state: validE←0, MulDivE←0, illegalE←0, cnt←0, state←IDLE, and instrD is not accepted that edge. A flush coincident with a BUSY cnt==1 edge suppresses the validE pulse.
- validD while readyD=0 is ignored. The upstream stage holds instrD; this block does not buffer it.

## Timing
- Reset (async assert) sets all E outputs to 0, validE=0, cnt=0, and state IDLE, so readyD=1 once reset deasserts. ImmSrcD stays combinational from instrD.
- Non-M latency: accept at edge t → validE=1 for the cycle after edge t. Back-to-back accepts run at one instruction per cycle.
- M latency: accept at edge t → readyD=0 after edges t..t+L-1 (L = MUL_LAT or DIV_LAT) → validE=1 and readyD=1 after edge t+L. The earliest next accept is edge t+L+1.
- validE for an M op is a single-cycle pulse unless a new instruction is accepted at the next edge.

## Test plan
- add 0x002081B3 with validD=1 → after 1 edge: validE=1, RegWriteE=1, ALUOpE=10, ALUSrcE=0, MulDivE=0, readyD stays 1.
- lw 0x00012083 then jalr 0x000100E7 back-to-back → ResultSrcE=01, then ResultSrcE=10 with JumpE=1 and jumpRegE=0, on consecutive cycles.
- mul 0x022081B3 (MUL_LAT=2) → readyD=0 for 2 cycles, validE=1 on the 3rd cycle with MulDivE=1 and mdOpE=000. div 0x0220C1B3 (DIV_LAT=8) → readyD=0 for 8 cycles.
- EN_M=0 with mul 0x022081B3, and separately opcode 0x0000007F → validE=1, illegalE=1, RegWriteE=0, MemWriteE=0.
- div accepted, flushE=1 on the 4th busy cycle → next cycle validE=0 and readyD=1, and no later validE pulse for the div.
- Assert reset asynchronously mid-BUSY (no clk edge) → validE, RegWriteE, MulDivE go 0 immediately; after deassert readyD=1 and cnt=0.
